// File: rtl/mmio_pkg.sv
// mmio_pkg: shared FSM encoding, default address map and timeout for mmio_bus
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    localparam logic [31:0] BRAM_BASE   = 32'h0000_0000;
    localparam logic [31:0] BRAM_SIZE   = 32'h0000_1000;
    localparam logic [31:0] GPIO_BASE   = 32'h0000_1000;
    localparam logic [31:0] GPIO_SIZE   = 32'hFFFF_F000;
    localparam int          DEF_TIMEOUT = 15;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmio_decode.sv
// mmio_decode: combinational region match with lowest-index priority and offset
module mmio_decode
    import mmio_pkg::*;
#(
    parameter int                         N_SLAVES  = 2,
    parameter int                         ADDR_W    = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] BASE_FLAT = {GPIO_BASE, BRAM_BASE},
    parameter logic [N_SLAVES*ADDR_W-1:0] SIZE_FLAT = {GPIO_SIZE, BRAM_SIZE},
    localparam int                        IDX_W     = idx_width(N_SLAVES)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] offset
);

    logic [N_SLAVES-1:0] match;

    genvar g;
    for (g = 0; g < N_SLAVES; g++) begin : g_rgn
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] size;
        assign base     = BASE_FLAT[g*ADDR_W +: ADDR_W];
        assign size     = SIZE_FLAT[g*ADDR_W +: ADDR_W];
        assign match[g] = (size != '0) && (addr >= base) &&
                          ({1'b0, addr} < ({1'b0, base} + {1'b0, size}));
    end

    // Scan from the highest region down so the lowest matching index is left standing
    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        offset = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit    = 1'b1;
                idx    = IDX_W'(k);
                offset = addr - BASE_FLAT[k*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/mmio_bus.sv
// mmio_bus: single-master MMIO interconnect with region decode, ack timeout and error count
module mmio_bus
    import mmio_pkg::*;
#(
    parameter int                         N_SLAVES  = 2,
    parameter int                         ADDR_W    = 32,
    parameter int                         DATA_W    = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] BASE_FLAT = {GPIO_BASE, BRAM_BASE},
    parameter logic [N_SLAVES*ADDR_W-1:0] SIZE_FLAT = {GPIO_SIZE, BRAM_SIZE},
    parameter int                         TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    input  logic [DATA_W/8-1:0]          req_be,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic [N_SLAVES-1:0]          s_sel,
    output logic                         s_we,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_be,
    input  logic [N_SLAVES-1:0]          s_ack,
    input  logic [N_SLAVES*DATA_W-1:0]   s_rdata,
    output logic [7:0]                   err_count
);

    localparam int IDX_W = idx_width(N_SLAVES);

    state_e              state_q, state_d;
    logic                we_q;
    logic [IDX_W-1:0]    idx_q;
    logic [ADDR_W-1:0]   off_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] be_q;
    logic [7:0]          tmo_q, tmo_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rerr_q, rerr_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                dec_hit;
    logic [IDX_W-1:0]    dec_idx;
    logic [ADDR_W-1:0]   dec_off;
    logic                accept;
    logic                ack;
    logic                err_evt;

    mmio_decode #(
        .N_SLAVES  (N_SLAVES),
        .ADDR_W    (ADDR_W),
        .BASE_FLAT (BASE_FLAT),
        .SIZE_FLAT (SIZE_FLAT)
    ) u_decode (
        .addr   (req_addr),
        .hit    (dec_hit),
        .idx    (dec_idx),
        .offset (dec_off)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign ack       = s_ack[idx_q];
    assign s_sel     = (state_q == ST_ACCESS) ? (N_SLAVES'(1) << idx_q) : '0;
    assign s_we      = we_q;
    assign s_addr    = off_q;
    assign s_wdata   = wdata_q;
    assign s_be      = be_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rerr_q;
    assign err_count = cnt_q;

    // Next state, timeout count and response capture; an ack beats a same-cycle timeout
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        err_evt = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tmo_d = '0;
                    if (dec_hit) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_RESP;
                        rdata_d = '0;
                        rerr_d  = 1'b1;
                        err_evt = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (ack) begin
                    state_d = ST_RESP;
                    rdata_d = we_q ? '0 : s_rdata[idx_q*DATA_W +: DATA_W];
                    rerr_d  = 1'b0;
                end else if (tmo_q == 8'(TIMEOUT - 1)) begin
                    state_d = ST_RESP;
                    rdata_d = '0;
                    rerr_d  = 1'b1;
                    err_evt = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        cnt_d = (err_evt && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end

    // State and response registers; request fields are captured on acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            idx_q   <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            tmo_q   <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                idx_q   <= dec_idx;
                off_q   <= dec_off;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

endmodule

// File: tb/tb_mmio_bus.sv
// tb_mmio_bus: vector table, directed corner sequences and randomized model check of mmio_bus
module tb_mmio_bus;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, rsp_valid, rsp_err, s_we;
    logic [31:0] rsp_rdata, s_addr, s_wdata;
    logic [3:0]  s_be;
    logic [1:0]  s_sel, s_ack;
    logic [63:0] s_rdata;
    logic [7:0]  err_count;
    logic        req_ready2, rsp_valid2, rsp_err2, s_we2;
    logic [31:0] rsp_rdata2, s_addr2, s_wdata2;
    logic [3:0]  s_be2;
    logic [1:0]  s_sel2;
    logic [7:0]  err_count2;

    int          n_chk = 0;
    int          n_err = 0;
    int          exp_cnt = 0;
    int          ack_lat = -1;
    int          sel_cnt = 0;
    logic [1:0]  spur_ack = '0;
    logic [31:0] sd = '0;

    longint base_m[2] = '{64'h0, 64'h1000};
    longint size_m[2] = '{64'h1000, 64'hFFFF_F000};

    always #5 clk = ~clk;

    mmio_bus dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_be(s_be), .s_ack(s_ack), .s_rdata(s_rdata), .err_count(err_count)
    );

    mmio_bus #(.SIZE_FLAT({32'h0, 32'h1000})) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid2),
        .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .s_sel(s_sel2), .s_we(s_we2), .s_addr(s_addr2),
        .s_wdata(s_wdata2), .s_be(s_be2), .s_ack(s_ack), .s_rdata(s_rdata), .err_count(err_count2)
    );

    assign s_rdata = {~sd, sd};
    assign s_ack   = ((s_sel != 2'b00 && ack_lat >= 0 && sel_cnt == ack_lat) ? s_sel : 2'b00) |
                     (spur_ack & ~s_sel);

    always @(posedge clk) sel_cnt <= (s_sel != 2'b00) ? sel_cnt + 1 : 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] sd;
        int          lat;
        logic [1:0]  spur;
        int          eidx;
        logic [31:0] eoff;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int region(input logic [31:0] a);
        longint x;
        x = a;
        for (int i = 0; i < 2; i++)
            if (size_m[i] != 0 && x >= base_m[i] && x < base_m[i] + size_m[i]) return i;
        return -1;
    endfunction

    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] data, input int lat,
                          input logic [1:0] spur, input int eidx, input logic [31:0] eoff,
                          input logic [31:0] erd, input logic eerr);
        int         sel_n, got_k, elat, esn;
        logic       sel_bad;
        logic [1:0] esel;
        esel    = (eidx < 0) ? 2'b00 : 2'(1 << eidx);
        elat    = (eidx < 0) ? 1 : (eerr ? TO + 1 : lat + 2);
        esn     = (eidx < 0) ? 0 : (eerr ? TO : lat + 1);
        ack_lat = lat;
        spur_ack = spur;
        sd      = data;
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
        #1 chk("ready_idle", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
        sel_n = 0; got_k = 0; sel_bad = 1'b0;
        for (int k = 1; k <= 40 && got_k == 0; k++) begin
            @(negedge clk);
            if (s_sel != 2'b00) begin
                if (sel_n == 0) begin
                    chk("s_sel", s_sel, esel);
                    chk("s_addr", s_addr, eoff);
                    chk("s_we", s_we, we);
                    chk("s_wdata", s_wdata, wdata);
                    chk("s_be", s_be, be);
                end else if (s_sel !== esel) sel_bad = 1'b1;
                sel_n++;
            end
            if (req_ready) sel_bad = 1'b1;
            if (rsp_valid) begin
                got_k = k;
                if (eerr && exp_cnt < 255) exp_cnt++;
                chk("rsp_rdata", rsp_rdata, erd);
                chk("rsp_err", rsp_err, eerr);
                chk("err_count", err_count, exp_cnt);
            end
        end
        chk("rsp_latency", got_k, elat);
        chk("sel_cycles", sel_n, esn);
        chk("busy_stable", sel_bad, 0);
        @(negedge clk);
        chk("rsp_pulse", rsp_valid, 0);
        chk("ready_back", req_ready, 1);
        chk("rdata_hold", rsp_rdata, erd);
        chk("err_hold", rsp_err, eerr);
        ack_lat = -1;
        spur_ack = 2'b00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx, lat, r;
        logic        we, eerr, seen;
        logic [31:0] addr, d;
        tbl[0] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hCAFE_F00D,  0, 2'b00, 0, 32'h10,        32'hCAFE_F00D, 1'b0};
        tbl[1] = '{1'b1, 32'h0000_1004, 32'h0000_000F, 4'h1, 32'h1234_5678,  0, 2'b00, 1, 32'h4,         32'h0,         1'b0};
        tbl[2] = '{1'b0, 32'h0000_0FFF, 32'h0,         4'hF, 32'h1234_5678,  2, 2'b10, 0, 32'hFFF,       32'h1234_5678, 1'b0};
        tbl[3] = '{1'b0, 32'h0000_1000, 32'h0,         4'hF, 32'hA5A5_0000,  1, 2'b01, 1, 32'h0,         32'h5A5A_FFFF, 1'b0};
        tbl[4] = '{1'b0, 32'hFFFF_FFFF, 32'h0,         4'hF, 32'h0BAD_BEEF,  0, 2'b00, 1, 32'hFFFF_EFFF, 32'hF452_4110, 1'b0};
        tbl[5] = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 32'h1111_2222, 14, 2'b10, 0, 32'h20,        32'h1111_2222, 1'b0};
        tbl[6] = '{1'b0, 32'h0000_0024, 32'h0,         4'hF, 32'h7777_7777, -1, 2'b10, 0, 32'h24,        32'h0,         1'b1};
        tbl[7] = '{1'b1, 32'h0000_1800, 32'h5555_AAAA, 4'hC, 32'h7777_7777, 15, 2'b01, 1, 32'h800,       32'h0,         1'b1};
        tbl[8] = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hA, 32'h3333_4444,  3, 2'b10, 0, 32'h8,         32'h0,         1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_s_sel", s_sel, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_err_count", err_count, 0);

        // A region of size zero never hits: the second bus sees a miss
        ack_lat = 0; sd = 32'h9999_9999;
        req_we = 1'b0; req_addr = 32'h0000_2000; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("miss_rsp_valid", rsp_valid2, 1);
        chk("miss_err", rsp_err2, 1);
        chk("miss_rdata", rsp_rdata2, 0);
        chk("miss_s_sel", s_sel2, 0);
        chk("miss_err_count", err_count2, 1);
        repeat (3) @(negedge clk);
        chk("miss_rsp_pulse", rsp_valid2, 0);
        chk("miss_err_count_hold", err_count2, 1);
        ack_lat = -1;

        for (int i = 0; i < 9; i++)
            do_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].sd, tbl[i].lat,
                   tbl[i].spur, tbl[i].eidx, tbl[i].eoff, tbl[i].erd, tbl[i].eerr);

        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom);
            r  = $urandom_range(0, 3);
            addr = (r == 0) ? 32'($urandom_range(0, 32'hFFF)) :
                   (r == 1) ? 32'h1000 + 32'($urandom_range(0, 255)) : $urandom;
            r  = $urandom_range(0, 9);
            lat = (r < 6) ? r : (r == 6) ? 14 : (r == 7) ? 15 : (r == 8) ? -1 : $urandom_range(4, 13);
            d   = $urandom;
            idx = region(addr);
            eerr = (idx < 0) || lat < 0 || lat >= TO;
            do_txn(we, addr, $urandom, 4'($urandom), d, lat, 2'($urandom), idx,
                   (idx < 0) ? 32'h0 : addr - 32'(base_m[idx]),
                   (eerr || we) ? 32'h0 : (idx == 0 ? d : ~d), eerr);
        end

        // Reset in the third ACCESS cycle aborts the transfer silently
        ack_lat = -1; spur_ack = 2'b10;
        req_we = 1'b0; req_addr = 32'h30; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_sel_before", s_sel, 2'b01);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        exp_cnt = 0;
        chk("abort_s_sel", s_sel, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_err_count", err_count, 0);
        chk("abort_ready", req_ready, 1);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("abort_no_rsp", seen, 0);
        spur_ack = 2'b00;

        for (int i = 0; i < 260; i++)
            do_txn(1'b0, 32'h40, 32'h0, 4'hF, 32'h0, -1, 2'b10, 0, 32'h40, 32'h0, 1'b1);
        chk("err_count_saturated", err_count, 255);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_bus.md
MMIO_BUS -- requirements
Module: mmio_bus

Interface
REQ-001 Parameter N_SLAVES, 2, number of slave regions (1..8).
REQ-002 Parameter ADDR_W, 32, address width.
REQ-003 Parameter DATA_W, 32, data width, multiple of 8.
REQ-004 Parameter BASE_FLAT, {32'h1000, 32'h0}, N_SLAVES x ADDR_W base addresses, region 0 in LSBs.
REQ-005 Parameter SIZE_FLAT, {32'hFFFF_F000, 32'h1000}, N_SLAVES x ADDR_W region sizes in bytes.
REQ-006 Parameter TIMEOUT, 15, max ACCESS cycles without ack before error (1..255).
REQ-007 One clock; reset is synchronous and active-high: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-008 req_valid in 1 request present; req_ready out 1 bus can accept; req_we in 1 write=1/read=0.
REQ-009 req_addr in ADDR_W byte address; req_wdata in DATA_W write data; req_be in DATA_W/8 byte enables.
REQ-010 rsp_valid out 1 one-cycle response strobe; rsp_rdata out DATA_W read data; rsp_err out 1 bus error.
REQ-011 s_sel out N_SLAVES one-hot slave select; s_we out 1; s_addr out ADDR_W region offset; s_wdata out DATA_W; s_be out DATA_W/8.
REQ-012 s_ack in N_SLAVES per-slave completion; s_rdata in N_SLAVES x DATA_W per-slave read data, slave 0 in LSBs.
REQ-013 err_count out 8 saturating count of error responses.

Function
REQ-014 FSM states IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 Request accepted on a rising edge with req_valid and req_ready both 1; req_we, req_addr, req_wdata, req_be latched that edge.
REQ-016 Region i hits when BASE_i <= addr < BASE_i + SIZE_i, sum computed in ADDR_W+1 bits (no wrap); SIZE_i = 0 never hits.
REQ-017 Overlapping hits: lowest index wins.
REQ-018 Hit: next state ACCESS; s_sel has exactly bit i set throughout ACCESS; s_addr = addr - BASE_i; s_we/s_wdata/s_be = latched values.
REQ-019 Miss: next state RESP directly; rsp_err=1, rsp_rdata=0; no s_sel asserted.
REQ-020 In ACCESS, only s_ack[i] of the selected slave is honoured; other acks ignored.
REQ-021 s_ack[i] sampled 1 in ACCESS: capture s_rdata slice i into rsp_rdata, rsp_err=0, next state RESP; ack in first ACCESS cycle permitted.
REQ-022 Minimum latency: accept at edge T, s_sel high cycle T..T+1, rsp_valid high in the cycle after the ack edge (accept-to-rsp_valid 2 cycles).
REQ-023 Timeout counter clears on entering ACCESS, increments each ACCESS cycle without ack; at TIMEOUT cycles: s_sel drops, next RESP, rsp_err=1, rsp_rdata=0.
REQ-024 Ack and timeout in same cycle: ack wins, no error.
REQ-025 RESP lasts exactly one cycle with rsp_valid=1, then IDLE; writes also produce a response (rsp_rdata=0).
REQ-026 rsp_valid=0 and s_sel=0 outside RESP and ACCESS respectively; rsp_rdata/rsp_err hold last value.
REQ-027 err_count increments by 1 per error response; saturates at 255.

Reset
REQ-028 rst=1 at an edge: state IDLE, s_sel=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, err_count=0, timeout counter=0, latched request fields=0.
REQ-029 Reset mid-ACCESS or mid-RESP aborts the transfer with no response; req_ready=1 in the first cycle after rst deasserts.

Structure
REQ-030 Package mmio_pkg holds the state encoding, default region constants (BRAM base 0 size 0x1000, GPIO base 0x1000) and the default TIMEOUT.
REQ-031 Sub-module mmio_decode: purely combinational range compare and priority encode, outputs hit flag, index, offset.

Verification
REQ-032 Read 0x0000_0010, slave 0 acks first ACCESS cycle with 0xCAFE_F00D -> rsp_valid 2 cycles after accept, rdata 0xCAFE_F00D, err 0.
REQ-033 Write 0x0000_1004 data 0x0000_000F be 4'b0001 -> s_sel=2'b10, s_addr=0x4, s_be=4'b0001, response err 0.
REQ-034 N_SLAVES=2, SIZE_FLAT={0,0x1000}, read 0x2000 -> no s_sel, rsp_err=1, rsp_rdata=0, err_count=1.
REQ-035 Slave 0 never acks, TIMEOUT=15 -> s_sel high 15 cycles, then rsp_err=1; spurious s_ack[1] during wait ignored.
REQ-036 rst asserted in 3rd ACCESS cycle -> no rsp_valid, s_sel=0 next cycle, err_count=0; 260 errors -> err_count=255.
